// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared load/store size codes and MMIO register offsets
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } sizeE;

  localparam logic [3:0] OFF_CNT_LO = 4'h0;
  localparam logic [3:0] OFF_CNT_HI = 4'h4;
  localparam logic [3:0] OFF_TOHOST = 4'h8;
  localparam logic [3:0] OFF_ERR    = 4'hC;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store lane replication and load extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addrLow,
  input  logic [2:0]  size,
  input  logic        isStore,
  input  logic [31:0] wdata,
  input  logic [31:0] ramWord,
  output logic        shapeOk,
  output logic [3:0]  byteEn,
  output logic [31:0] laneWdata,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = ramWord[8*addrLow +: 8];
  assign halfSel = addrLow[1] ? ramWord[31:16] : ramWord[15:0];

  always_comb begin
    shapeOk   = 1'b0;
    byteEn    = 4'b0000;
    laneWdata = wdata;
    loadData  = '0;
    case (size)
      SZ_B: begin
        shapeOk   = 1'b1;
        byteEn    = 4'b0001 << addrLow;
        laneWdata = {4{wdata[7:0]}};
        loadData  = {{24{byteSel[7]}}, byteSel};
      end
      SZ_H: begin
        shapeOk   = !addrLow[0];
        byteEn    = addrLow[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{wdata[15:0]}};
        loadData  = {{16{halfSel[15]}}, halfSel};
      end
      SZ_W: begin
        shapeOk   = (addrLow == 2'b00);
        byteEn    = 4'b1111;
        loadData  = ramWord;
      end
      // unsigned codes are load-only
      SZ_BU: begin
        shapeOk   = !isStore;
        loadData  = {24'b0, byteSel};
      end
      SZ_HU: begin
        shapeOk   = !isStore && !addrLow[0];
        loadData  = {16'b0, halfSel};
      end
      default: begin
        shapeOk   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - zero-wait data memory: RAM plus optional MMIO block
// (cycle counter, tohost, error register) enabled by `DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  output logic [31:0] dmemRdata,
  output logic        halt,
  output logic [31:0] exitCode,
  output logic        accessErr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ramIdx;
  logic [31:0]   ramWord;
  logic          inRam;
  logic          mmioHit;
  logic          illegal;
  logic          ramWrite;
  logic          errClear;
  logic          shapeOk;
  logic [3:0]    byteEn;
  logic [31:0]   laneWdata;
  logic [31:0]   loadData;
  logic [31:0]   rdataRaw;

  assign inRam   = {1'b0, dmemAddr} < RAM_BYTES;
  assign mmioHit = (dmemAddr[31:4] == MMIO_BASE[31:4]);
  assign ramIdx  = dmemAddr[AW+1:2];
  assign ramWord = inRam ? ram[ramIdx] : '0;

  dmem_lane_align uAlign (
    .addrLow  (dmemAddr[1:0]),
    .size     (dmemSize),
    .isStore  (dmemWen),
    .wdata    (dmemWdata),
    .ramWord  (ramWord),
    .shapeOk  (shapeOk),
    .byteEn   (byteEn),
    .laneWdata(laneWdata),
    .loadData (loadData)
  );

`ifdef DMEM_MMIO_EN
  logic [63:0] cycleCnt;
  logic        haltQ;
  logic [31:0] exitQ;
  logic        mmioWrite;
  logic [31:0] mmioRdata;

  assign illegal   = !shapeOk || !(inRam || mmioHit) || (mmioHit && dmemSize != SZ_W);
  assign mmioWrite = dmemWen && mmioHit && !illegal;
  assign errClear  = mmioWrite && (dmemAddr[3:0] == OFF_ERR) && dmemWdata[0];

  always_comb begin
    mmioRdata = '0;
    case (dmemAddr[3:0])
      OFF_CNT_LO: mmioRdata = cycleCnt[31:0];
      OFF_CNT_HI: mmioRdata = cycleCnt[63:32];
      OFF_TOHOST: mmioRdata = exitQ;
      OFF_ERR:    mmioRdata = {31'b0, accessErr};
      default:    mmioRdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCnt <= '0;
      haltQ    <= 1'b0;
      exitQ    <= '0;
    end else begin
      cycleCnt <= cycleCnt + 64'd1;
      // only the first tohost write is latched
      if (mmioWrite && dmemAddr[3:0] == OFF_TOHOST && !haltQ) begin
        haltQ <= 1'b1;
        exitQ <= dmemWdata;
      end
    end
  end

  assign rdataRaw = mmioHit ? mmioRdata : loadData;
  assign halt     = haltQ;
  assign exitCode = exitQ;
`else
  // the window is decoded only so it stays out-of-range even if RAM grows over it
  assign illegal  = !shapeOk || !inRam || mmioHit;
  assign errClear = 1'b0;
  assign rdataRaw = loadData;
  assign halt     = 1'b0;
  assign exitCode = '0;
`endif

  assign dmemRdata = (!rst || illegal) ? '0 : rdataRaw;
  assign ramWrite  = rst && dmemWen && !illegal && inRam;

  always_ff @(posedge clk) begin
    if (ramWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) ram[ramIdx][8*i +: 8] <= laneWdata[8*i +: 8];
      end
    end
  end

  // a new error in the same cycle wins over a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          accessErr <= 1'b0;
    else if (illegal)  accessErr <= 1'b1;
    else if (errClear) accessErr <= 1'b0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed bench for dmem_responder
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] MB    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmemAddr, dmemWdata, dmemRdata, exitCode;
  logic [2:0]  dmemSize;
  logic        dmemWen, halt, accessErr;

  int nCompared = 0;
  int nMismatch = 0;

  logic [7:0] mref [256];
  bit         errModel = 1'b0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .dmemAddr (dmemAddr),
    .dmemWdata(dmemWdata),
    .dmemSize (dmemSize),
    .dmemWen  (dmemWen),
    .dmemRdata(dmemRdata),
    .halt     (halt),
    .exitCode (exitCode),
    .accessErr(accessErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit isLegal(input logic [31:0] a, input logic [2:0] sz, input logic we);
    if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b0;
    if ((sz == 3'd1 || sz == 3'd5) && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    if (a >= 32'(4 * DEPTH)) return 1'b0;
    if (we && sz[2]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] sz);
    int     n = 1 << sz[1:0];
    longint v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(mref[int'(a[7:0]) + i]) << (8 * i));
    if (!sz[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic refStore(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n = 1 << sz[1:0];
    for (int i = 0; i < n; i++) mref[int'(a[7:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic access(input logic [31:0] a, input logic [2:0] sz, input logic we, input logic [31:0] wd);
    dmemAddr = a; dmemSize = sz; dmemWen = we; dmemWdata = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dmemAddr = '0; dmemSize = 3'd2; dmemWen = 1'b0; dmemWdata = '0;
  endtask

  task automatic run(input logic [31:0] a, input logic [2:0] sz, input logic we,
                     input logic [31:0] wd, output logic [31:0] rd);
    bit          ok;
    logic [31:0] expv;
    ok   = isLegal(a, sz, we);
    expv = ok ? refLoad(a, sz) : 32'h0;
    access(a, sz, we, wd);
    rd = dmemRdata;
    if (!we || !ok) check($sformatf("rdata a=%h sz=%0d we=%0d", a, sz, we), rd, expv);
    tick();
    if (ok && we) refStore(a, sz, wd);
    if (!ok) errModel = 1'b1;
    check($sformatf("accessErr a=%h sz=%0d we=%0d", a, sz, we), {31'b0, accessErr}, {31'b0, errModel});
  endtask

  task automatic clearErr();
`ifdef DMEM_MMIO_EN
    access(MB + 32'hC, 3'd2, 1'b1, 32'h1);
    tick();
`else
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
`endif
    errModel = 1'b0;
    check("accessErr cleared", {31'b0, accessErr}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [2:0]  sz;
    logic        we;

    rst = 1'b0;
    dmemAddr = '0; dmemSize = 3'd2; dmemWen = 1'b0; dmemWdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rdata", dmemRdata, 32'h0);
    check("reset halt", {31'b0, halt}, 32'h0);
    check("reset exitCode", exitCode, 32'h0);
    check("reset accessErr", {31'b0, accessErr}, 32'h0);

    rst = 1'b1;
`ifdef DMEM_MMIO_EN
    repeat (10) @(posedge clk);
    #1;
    access(MB, 3'd2, 1'b0, 32'h0);
    check("counter lo after 10", dmemRdata, 32'd10);
    tick();
    access(MB + 32'h4, 3'd2, 1'b0, 32'h0);
    check("counter hi", dmemRdata, 32'h0);
    tick();
`endif

    for (int w = 0; w < 64; w++) run(32'(4 * w), 3'd2, 1'b1, $urandom, rd);

    run(32'h10, 3'd2, 1'b1, 32'hDEADBEEF, rd);
    run(32'h13, 3'd0, 1'b0, 32'h0, rd);  check("LB 0x13", rd, 32'hFFFFFFDE);
    run(32'h13, 3'd4, 1'b0, 32'h0, rd);  check("LBU 0x13", rd, 32'h000000DE);
    run(32'h10, 3'd5, 1'b0, 32'h0, rd);  check("LHU 0x10", rd, 32'h0000BEEF);
    run(32'h12, 3'd1, 1'b0, 32'h0, rd);  check("LH 0x12", rd, 32'hFFFFDEAD);

    run(32'h11, 3'd0, 1'b1, 32'h12, rd);
    run(32'h10, 3'd2, 1'b0, 32'h0, rd);  check("LW after SB", rd, 32'hDEAD12EF);

    run(32'h12, 3'd2, 1'b1, 32'hCAFEF00D, rd);
    check("misaligned SW err", {31'b0, accessErr}, 32'h1);
    run(32'h10, 3'd2, 1'b0, 32'h0, rd);  check("LW unchanged", rd, 32'hDEAD12EF);
`ifdef DMEM_MMIO_EN
    access(MB + 32'hC, 3'd2, 1'b0, 32'h0);
    check("err reg read", dmemRdata, 32'h1);
    tick();
`endif
    clearErr();

    for (int k = 0; k < 150; k++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'($urandom_range(0, 255));
      sz = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      run(a, sz, we, wd, rd);
      if (errModel) clearErr();
    end

    run(32'(4 * DEPTH), 3'd2, 1'b0, 32'h0, rd);
    check("LW out of range err", {31'b0, accessErr}, 32'h1);
    clearErr();
    run(32'h0, 3'd3, 1'b0, 32'h0, rd);
    check("size 011 err", {31'b0, accessErr}, 32'h1);
    clearErr();

`ifdef DMEM_MMIO_EN
    access(MB, 3'd2, 1'b1, 32'h1234);
    tick();
    check("RO write no err", {31'b0, accessErr}, 32'h0);
    access(MB + 32'h8, 3'd2, 1'b1, 32'h1);
    tick();
    check("halt set", {31'b0, halt}, 32'h1);
    check("exitCode first", exitCode, 32'h1);
    access(MB + 32'h8, 3'd2, 1'b1, 32'h5);
    tick();
    check("exitCode held", exitCode, 32'h1);
    access(MB + 32'h8, 3'd2, 1'b0, 32'h0);
    check("tohost read", dmemRdata, 32'h1);
    tick();
    access(MB, 3'd0, 1'b0, 32'h0);
    check("MMIO byte rdata", dmemRdata, 32'h0);
    tick();
    check("MMIO byte err", {31'b0, accessErr}, 32'h1);
    clearErr();
`else
    access(MB, 3'd2, 1'b0, 32'h0);
    check("MMIO disabled rdata", dmemRdata, 32'h0);
    tick();
    check("MMIO disabled err", {31'b0, accessErr}, 32'h1);
    check("MMIO disabled halt", {31'b0, halt}, 32'h0);
    clearErr();
`endif

    run(32'h20, 3'd2, 1'b1, 32'h11223344, rd);
    access(32'h20, 3'd2, 1'b1, 32'hAAAA5555);
    rst = 1'b0;
    #1;
    check("in-reset rdata", dmemRdata, 32'h0);
    check("in-reset halt", {31'b0, halt}, 32'h0);
    check("in-reset exitCode", exitCode, 32'h0);
    check("in-reset accessErr", {31'b0, accessErr}, 32'h0);
    @(posedge clk);
    #1;
    check("in-reset rdata after edge", dmemRdata, 32'h0);
    dmemAddr = '0; dmemSize = 3'd2; dmemWen = 1'b0; dmemWdata = '0;
    rst = 1'b1;
    errModel = 1'b0;
    #1;
    run(32'h20, 3'd2, 1'b0, 32'h0, rd);
    check("word kept over reset", rd, 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
